// File: rtl/exc_ctrl_mc.sv
// Exception controller: fixed-priority take, one-level handler, ERET return.
// Captures ELR/ESR/ESRC on entry and redirects fetch on take and return.
module exc_ctrl_mc #(
  parameter int          N     = 64,
  parameter int          NSRC  = 4,
  parameter logic [N-1:0] VBASE = 64'h0000_0000_0000_D800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC-1:0]   exc_req,
  input  logic [4*NSRC-1:0] exc_code,
  input  logic [NSRC-1:0]   exc_mask,
  input  logic              eret,
  input  logic [N-1:0]      pc_next,
  input  logic [1:0]        sysreg_sel,
  output logic              eproc,
  output logic [N-1:0]      evaddr,
  output logic [NSRC-1:0]   exc_ack,
  output logic [N-1:0]      sysreg_rdata,
  output logic              in_handler
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_TAKE,
    S_HANDLER,
    S_RET
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [N-1:0]   r_elr;
  logic [N-1:0]   r_esr;
  logic [N-1:0]   r_esrc;
  logic [NSRC-1:0] w_cand;
  logic           w_any;
  logic [3:0]     w_win_idx;
  logic [3:0]     w_win_code;
  logic [N-1:0]   w_sysreg;

  assign w_cand = exc_req & ~exc_mask;

  // Lowest-index unmasked request wins; scan high to low so low index overwrites.
  always_comb begin
    w_any      = 1'b0;
    w_win_idx  = 4'd0;
    w_win_code = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (w_cand[i]) begin
        w_any      = 1'b1;
        w_win_idx  = 4'(i);
        w_win_code = exc_code[4*i +: 4];
      end
    end
  end

  // State register and syndrome capture on the IDLE->TAKE edge only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_elr   <= '0;
      r_esr   <= '0;
      r_esrc  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE && w_any) begin
        r_elr  <= pc_next;
        r_esr  <= {{(N-4){1'b0}}, w_win_code};
        r_esrc <= {{(N-4){1'b0}}, w_win_idx};
      end
    end
  end

  // MRS read mux over the saved exception registers.
  always_comb begin
    w_sysreg = '0;
    unique case (sysreg_sel)
      2'b00: w_sysreg = r_elr;
      2'b01: w_sysreg = r_esr;
      2'b10: w_sysreg = r_esrc;
      2'b11: w_sysreg = '0;
    endcase
  end

  // Next state and redirect/ack outputs; everything forced quiet while reset is high.
  always_comb begin
    w_state_nxt  = r_state;
    eproc        = 1'b0;
    evaddr       = '0;
    exc_ack      = '0;
    in_handler   = 1'b0;
    sysreg_rdata = w_sysreg;
    unique case (r_state)
      S_IDLE: begin
        if (w_any) w_state_nxt = S_TAKE;
      end
      S_TAKE: begin
        eproc       = 1'b1;
        evaddr      = VBASE + (r_esrc << 7);
        in_handler  = 1'b1;
        w_state_nxt = S_HANDLER;
        for (int i = 0; i < NSRC; i++) begin
          exc_ack[i] = (r_esrc == N'(i));
        end
      end
      S_HANDLER: begin
        in_handler = 1'b1;
        if (eret) w_state_nxt = S_RET;
      end
      S_RET: begin
        eproc       = 1'b1;
        evaddr      = r_elr;
        w_state_nxt = S_IDLE;
      end
    endcase
    if (reset) begin
      eproc        = 1'b0;
      evaddr       = '0;
      exc_ack      = '0;
      in_handler   = 1'b0;
      sysreg_rdata = '0;
    end
  end

endmodule

// File: tb/tb_exc_ctrl_mc.sv
// Testbench for exc_ctrl_mc: directed scenarios plus random traffic
// checked every cycle against a behavioural exception model.
module tb_exc_ctrl_mc;

  localparam int N    = 64;
  localparam int NSRC = 4;
  localparam logic [63:0] VB = 64'hD800;

  logic              clk = 1'b0;
  logic              reset;
  logic [NSRC-1:0]   exc_req;
  logic [4*NSRC-1:0] exc_code;
  logic [NSRC-1:0]   exc_mask;
  logic              eret;
  logic [N-1:0]      pc_next;
  logic [1:0]        sysreg_sel;
  logic              eproc;
  logic [N-1:0]      evaddr;
  logic [NSRC-1:0]   exc_ack;
  logic [N-1:0]      sysreg_rdata;
  logic              in_handler;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: saved registers, whether software is inside a handler,
  // and what redirect (if any) is visible this cycle.
  logic [63:0] m_elr, m_esr, m_esrc;
  bit          m_hdl;
  int          m_kind; // 0 none, 1 exception entry, 2 return

  exc_ctrl_mc dut (
    .clk(clk), .reset(reset), .exc_req(exc_req), .exc_code(exc_code),
    .exc_mask(exc_mask), .eret(eret), .pc_next(pc_next),
    .sysreg_sel(sysreg_sel), .eproc(eproc), .evaddr(evaddr),
    .exc_ack(exc_ack), .sysreg_rdata(sysreg_rdata),
    .in_handler(in_handler)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    int w;
    if (reset) begin
      m_elr = 0; m_esr = 0; m_esrc = 0;
      m_hdl = 0; m_kind = 0;
    end else if (m_kind == 1) begin
      m_kind = 0; m_hdl = 1;
    end else if (m_kind == 2) begin
      m_kind = 0; m_hdl = 0;
    end else if (m_hdl) begin
      if (eret) m_kind = 2;
    end else begin
      w = -1;
      for (int i = 0; i < NSRC; i++)
        if (w < 0 && exc_req[i] && !exc_mask[i]) w = i;
      if (w >= 0) begin
        m_elr  = pc_next;
        m_esr  = 64'((exc_code >> (4 * w)) & 16'hF);
        m_esrc = 64'(w);
        m_kind = 1;
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] e_addr, e_sr;
    logic [NSRC-1:0] e_ack;
    bit e_proc, e_ih;
    e_proc = (m_kind != 0);
    e_addr = (m_kind == 1) ? VB + m_esrc * 128 :
             (m_kind == 2) ? m_elr : 64'd0;
    e_ack  = (m_kind == 1) ? NSRC'(1) << m_esrc : '0;
    e_ih   = (m_kind == 1) || (m_hdl && m_kind == 0);
    case (sysreg_sel)
      2'b00: e_sr = m_elr;
      2'b01: e_sr = m_esr;
      2'b10: e_sr = m_esrc;
      default: e_sr = 0;
    endcase
    if (reset) begin
      e_proc = 0; e_addr = 0; e_ack = 0; e_ih = 0; e_sr = 0;
    end
    chk("eproc", 64'(eproc), 64'(e_proc));
    chk("evaddr", evaddr, e_addr);
    chk("exc_ack", 64'(exc_ack), 64'(e_ack));
    chk("in_handler", 64'(in_handler), 64'(e_ih));
    chk("sysreg", sysreg_rdata, e_sr);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_inputs();
    reset = 0; exc_req = 0; exc_code = 0; exc_mask = 0;
    eret = 0; pc_next = 0; sysreg_sel = 0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel,
                    input logic [63:0] exp);
    sysreg_sel = sel;
    #1;
    chk(tag, sysreg_rdata, exp);
  endtask

  initial begin
    m_elr = 0; m_esr = 0; m_esrc = 0; m_hdl = 0; m_kind = 0;
    idle_inputs();
    reset = 1;
    @(negedge clk);
    cycle();
    cycle();
    reset = 0;
    cycle();
    chk("rst_eproc", 64'(eproc), 64'd0);
    chk("rst_ih", 64'(in_handler), 64'd0);
    rd("rst_elr", 2'b00, 64'd0);

    // Single source, code 3, PC 0x40
    exc_req = 4'b0010; exc_code = 16'h0030; pc_next = 64'h40;
    cycle();
    chk("d1_eproc", 64'(eproc), 64'd1);
    chk("d1_evaddr", evaddr, 64'hD880);
    chk("d1_ack", 64'(exc_ack), 64'b0010);
    exc_req = 0; pc_next = 64'h99;
    cycle();
    chk("d1_hdl_eproc", 64'(eproc), 64'd0);
    rd("d1_esr", 2'b01, 64'd3);
    rd("d1_elr", 2'b00, 64'h40);
    rd("d1_zero", 2'b11, 64'd0);

    // Return
    eret = 1;
    cycle();
    chk("d2_ret_addr", evaddr, 64'h40);
    eret = 0;
    cycle();
    chk("d2_idle_ih", 64'(in_handler), 64'd0);
    chk("d2_idle_ep", 64'(eproc), 64'd0);

    // Priority with masking
    exc_req = 4'b1110; exc_mask = 4'b0010;
    cycle();
    chk("d3_evaddr", evaddr, 64'hD900);
    rd("d3_esrc", 2'b10, 64'd2);
    exc_req = 4'b0001; exc_mask = 0;
    // No nesting while in handler
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("d4_nonest", 64'(eproc), 64'd0);
    end
    eret = 1;
    cycle();
    eret = 0;
    cycle();
    chk("d4_idle", 64'(eproc), 64'd0);
    cycle();
    chk("d4_take0", evaddr, 64'hD800);
    exc_req = 0;
    cycle();

    // Reset in handler
    reset = 1;
    cycle();
    reset = 0;
    cycle();
    rd("d5_elr", 2'b00, 64'd0);
    rd("d5_esrc", 2'b10, 64'd0);
    eret = 1;
    cycle();
    chk("d5_eret_ign", 64'(eproc), 64'd0);
    // eret in IDLE again, no requests
    cycle();
    chk("d6_eret_idle", 64'(eproc), 64'd0);
    eret = 0;

    // Random traffic
    for (int t = 0; t < 3000; t++) begin
      reset    = ($urandom_range(0, 59) == 0);
      exc_req  = ($urandom_range(0, 3) == 0) ? NSRC'($urandom) : '0;
      exc_mask = NSRC'($urandom);
      exc_code = 16'($urandom);
      eret     = ($urandom_range(0, 3) == 0);
      pc_next  = {$urandom, $urandom};
      sysreg_sel = 2'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
